instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Program-counter and IF/ID pipeline-register stage that sits directly upstream of the instruction memory. It drives the byte address into the memory's combinational read port, captures the returned 32-bit little-endian word into an IF/ID register, and hands it to decode over a valid/ready handshake. It handles redirects (branch/jump/flush), decode back-pressure and fetch faults (misaligned or out-of-range PC), and keeps a count of delivered instructions.

## Interface
Clock is iClk; reset is iRstN, asynchronous and active-low. The block uses one clock.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset
- MEM_BYTES, 1024, instruction memory size in bytes; a legal PC satisfies PC ≤ MEM_BYTES−4

Ports:
- iClk  in  1  clock, rising edge
- iRstN  in  1  async active-low reset
- oImemAddr  out  32  byte address to instruction memory, equals PC register
- iImemInstr  in  32  word returned combinationally by memory for oImemAddr
- oIfValid  out  1  IF/ID holds an instruction for decode
- iIdReady  in  1  decode accepts IF/ID this cycle
- oIfInstr  out  32  fetched instruction
- oIfPc  out  32  PC of oIfInstr
- oIfPcPlus4  out  32  oIfPc + 4, modulo 2^32
- oIfFault  out  1  entry is a fault marker (misaligned/out-of-range); oIfInstr = 0
- iRedirect  in  1  discard in-flight work and restart fetch at iRedirectPc
- iRedirectPc  in  32  redirect target
- oFetchCount  out  32  number of entries accepted by decode (valid & ready), wraps

## Operation
- States: IDLE, FETCH, HALT.
  - IDLE: entered on reset; no fetch. Moves to FETCH after one cycle.
  - FETCH: normal operation.
  - HALT: entered after a fault entry is loaded. No fetch; PC frozen. Left only by iRedirect, which goes to FETCH.
- Load condition: load = (state == FETCH) & (!oIfValid | iIdReady) & !iRedirect.
- On load with a legal PC (PC[1:0] == 0 and PC ≤ MEM_BYTES−4):
  - IF/ID ← {valid=1, instr=iImemInstr, pc=PC, fault=0}.
  - PC ← PC+4.
- On load with an illegal PC:
  - IF/ID ← {valid=1, instr=0, pc=PC, fault=1}.
  - PC is held; state goes to HALT.
- Handshake:
  - If oIfValid & iIdReady and there is no load, valid clears next cycle.
  - While oIfValid & !iIdReady, all IF/ID outputs hold stable.
- Redirect has highest priority, in every state:
  - PC ← iRedirectPc.
  - oIfValid ← 0 (flush, regardless of iIdReady).
  - State ← FETCH.
  - Nothing is loaded that cycle.
  - iRedirectPc legality is checked when that PC is fetched, not at redirect.
- If iRedirect and a decode accept (oIfValid & iIdReady) happen in the same cycle, the accept still counts in oFetchCount.
- oFetchCount increments on every oIfValid & iIdReady, including fault entries.

## Timing
- Reset values:
  - PC = RESET_PC, so oImemAddr = RESET_PC.
  - State = IDLE.
  - oIfValid = 0, oIfInstr = 0, oIfPc = 0, oIfFault = 0, oFetchCount = 0.
  - oIfPcPlus4 = 4, because it is derived combinationally from oIfPc.
- First valid instruction appears on the second rising edge after iRstN deasserts (1 IDLE cycle, then 1 load).
- Fetch latency is 1 cycle: PC is presented in cycle n, and the instruction appears on oIfInstr in cycle n+1.
- Throughput is one instruction per cycle while iIdReady is held high.
- Redirect penalty: redirect asserted in cycle n gives oIfValid = 0 in cycle n+1, and the target instruction is valid in cycle n+2.
- Asserting reset mid-operation immediately forces all reset values (asynchronous); an in-flight entry is lost.
- PC wrap: PC+4 past 2^32 wraps. Such a PC is already out of range, so the fault path triggers first.

## Structure
- Shared package (fetch_pkg):
  - State enum {IDLE, FETCH, HALT}.
  - INSTR_W = 32, ADDR_W = 32.
  - Localparam for the fault instruction value (32'h0).
- One sub-module: if_id_reg, holding the valid/instr/pc/fault register with load/flush/hold control.
- PC register, FSM, legality check and counter live in instr_fetch_unit.

## Test plan
- Reset, then iIdReady = 1 with a memory model containing words 0x11111111 at address 0 and 0x22222222 at address 4 → oIfValid rises on the 2nd edge with oIfInstr = 0x11111111, oIfPc = 0; the next cycle gives 0x22222222, oIfPc = 4.
- iIdReady = 0 for 3 cycles while valid → oIfInstr and oIfPc stable and oImemAddr frozen; release → stream resumes with no skipped or duplicated PC, and oFetchCount matches the number of accepts.
- iRedirect = 1 with iRedirectPc = 0x40 while valid and stalled → next cycle oIfValid = 0; the following cycle oIfPc = 0x40 and oImemAddr = 0x44.
- Redirect to 0x42 → entry with oIfFault = 1, oIfInstr = 0, oIfPc = 0x42; oImemAddr holds 0x42 (state HALT); redirect to 0x0 → fetching resumes.
- Sequential fetch up to PC = 0x3FC (MEM_BYTES = 1024) → 0x3FC is delivered normally; PC = 0x400 produces a fault entry; redirect to 0x3FD also faults.
- Assert iRstN low mid-stream → all outputs take reset values immediately; after release, the first fetch is again at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  // Value presented on the instruction bus for a fault marker entry.
  localparam logic [INSTR_W-1:0] FAULT_INSTR = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  // A PC is fetchable when word aligned and the whole word lies inside memory.
  function automatic logic isLegalPc(input logic [ADDR_W-1:0] pc,
                                     input logic [ADDR_W-1:0] lastPc);
    return (pc[1:0] == 2'b00) && (pc <= lastPc);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction memory read port, IF/ID handshake to decode,
// redirect request and the delivered-instruction counter.
interface instr_fetch_unit_if;
  import fetch_pkg::*;

  logic [ADDR_W-1:0]  oImemAddr;
  logic [INSTR_W-1:0] iImemInstr;
  logic               oIfValid;
  logic               iIdReady;
  logic [INSTR_W-1:0] oIfInstr;
  logic [ADDR_W-1:0]  oIfPc;
  logic [ADDR_W-1:0]  oIfPcPlus4;
  logic               oIfFault;
  logic               iRedirect;
  logic [ADDR_W-1:0]  iRedirectPc;
  logic [31:0]        oFetchCount;

  // Fetch unit side.
  modport master (
    output oImemAddr,
    input  iImemInstr,
    output oIfValid,
    input  iIdReady,
    output oIfInstr,
    output oIfPc,
    output oIfPcPlus4,
    output oIfFault,
    input  iRedirect,
    input  iRedirectPc,
    output oFetchCount
  );

  // Environment side: memory, decode and redirect source.
  modport slave (
    input  oImemAddr,
    output iImemInstr,
    input  oIfValid,
    output iIdReady,
    input  oIfInstr,
    input  oIfPc,
    input  oIfPcPlus4,
    input  oIfFault,
    output iRedirect,
    output iRedirectPc,
    input  oFetchCount
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds one fetched entry for decode.
// Flush beats load, load beats consume; otherwise the entry holds.
module if_id_reg
  import fetch_pkg::*;
(
  input  logic               iClk,
  input  logic               iRstN,
  input  logic               iLoad,
  input  logic               iFlush,
  input  logic               iConsume,
  input  logic [INSTR_W-1:0] iInstr,
  input  logic [ADDR_W-1:0]  iPc,
  input  logic               iFault,
  output logic               oValid,
  output logic [INSTR_W-1:0] oInstr,
  output logic [ADDR_W-1:0]  oPc,
  output logic               oFault
);

  logic               validQ;
  logic [INSTR_W-1:0] instrQ;
  logic [ADDR_W-1:0]  pcQ;
  logic               faultQ;

  // Entry register; payload only changes on load so a stalled entry stays stable.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      validQ <= 1'b0;
      instrQ <= '0;
      pcQ    <= '0;
      faultQ <= 1'b0;
    end else if (iFlush) begin
      validQ <= 1'b0;
    end else if (iLoad) begin
      validQ <= 1'b1;
      instrQ <= iInstr;
      pcQ    <= iPc;
      faultQ <= iFault;
    end else if (iConsume) begin
      validQ <= 1'b0;
    end
  end

  assign oValid = validQ;
  assign oInstr = instrQ;
  assign oPc    = pcQ;
  assign oFault = faultQ;

endmodule

// File: rtl/instr_fetch_unit.sv
// Program counter, fetch FSM, PC legality check and delivered-instruction
// counter; the fetched entry itself lives in if_id_reg.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned       MEM_BYTES = 1024
) (
  input  logic                 iClk,
  input  logic                 iRstN,
  instr_fetch_unit_if.master   bus
);

  // Highest byte address at which a full word still fits in memory.
  localparam logic [ADDR_W-1:0] LastPc = ADDR_W'(MEM_BYTES - 4);

  fetch_state_e       stateQ;
  logic [ADDR_W-1:0]  pcQ;
  logic [31:0]        countQ;

  logic               pcLegal;
  logic               load;
  logic               consume;
  logic [INSTR_W-1:0] loadInstr;

  assign pcLegal   = isLegalPc(pcQ, LastPc);
  assign consume   = bus.oIfValid & bus.iIdReady;
  // Load only when IF/ID is empty or being drained this cycle.
  assign load      = (stateQ == FETCH) & (!bus.oIfValid | bus.iIdReady) & !bus.iRedirect;
  assign loadInstr = pcLegal ? bus.iImemInstr : FAULT_INSTR;

  // FSM and PC: redirect wins in every state; a fault freezes the PC in HALT.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      stateQ <= IDLE;
      pcQ    <= RESET_PC;
    end else if (bus.iRedirect) begin
      stateQ <= FETCH;
      pcQ    <= bus.iRedirectPc;
    end else begin
      unique case (stateQ)
        IDLE: stateQ <= FETCH;
        FETCH: begin
          if (load) begin
            if (pcLegal) begin
              pcQ <= pcQ + ADDR_W'(4);
            end else begin
              stateQ <= HALT;
            end
          end
        end
        HALT:    stateQ <= HALT;
        default: stateQ <= IDLE;
      endcase
    end
  end

  // Counts every decode accept, fault markers and redirect-cycle accepts included.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      countQ <= '0;
    end else if (consume) begin
      countQ <= countQ + 32'd1;
    end
  end

  if_id_reg uIfIdReg (
    .iClk     (iClk),
    .iRstN    (iRstN),
    .iLoad    (load),
    .iFlush   (bus.iRedirect),
    .iConsume (consume),
    .iInstr   (loadInstr),
    .iPc      (pcQ),
    .iFault   (!pcLegal),
    .oValid   (bus.oIfValid),
    .oInstr   (bus.oIfInstr),
    .oPc      (bus.oIfPc),
    .oFault   (bus.oIfFault)
  );

  assign bus.oImemAddr   = pcQ;
  assign bus.oFetchCount = countQ;
  assign bus.oIfPcPlus4  = bus.oIfPc + ADDR_W'(4);

endmodule
